pixel_readback_tx: RTL and testbench



---
 rtl/pixel_readback_tx_if.sv | 34 +++
 rtl/pixel_readback_tx.sv | 173 +++++++++++++++++
 tb/tb_pixel_readback_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_readback_tx_if.sv
// rtl/pixel_readback_tx_if.sv - SRAM read port and MCU pixel stream bundle
// master = readback engine, slave = SRAM/MCU side.
interface pixel_readback_tx_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output tx_valid,
    output tx_data,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  tx_valid,
    input  tx_data,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/pixel_readback_tx.sv
// rtl/pixel_readback_tx.sv - raster readback of pixel SRAM through a credit-limited FIFO to the MCU
// Define READBACK_CHECKSUM_EN to add a 16-bit running sum of transmitted pixels.
module pixel_readback_tx #(
  parameter int IMAGEX           = 64,
  parameter int IMAGEY           = 64,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  pixel_readback_tx_if.master bus,
  output logic                busy,
  output logic                done
`ifdef READBACK_CHECKSUM_EN
  ,
  output logic [15:0]         checksum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_IDX = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [IMAGE_ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [IMAGE_ADDR_WIDTH-1:0] send_cnt_q, send_cnt_d;
  logic                        inflight_q, inflight_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [RGB_SIZE-1:0]         fifo_mem_q [FIFO_DEPTH];
  logic [RGB_SIZE-1:0]         fifo_mem_d [FIFO_DEPTH];

  logic rd_en;
  logic push;
  logic pop;
  logic tx_valid;
  logic credit_ok;

  // A read may only be issued if the FIFO can still hold it together with the one already in flight.
  always_comb begin
    credit_ok = (({1'b0, count_q} + (CNT_W + 1)'(inflight_q) + (CNT_W + 1)'(1)) <= CREDIT_LIMIT);
  end

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    send_cnt_d = send_cnt_q;
    rd_en      = 1'b0;
    done       = 1'b0;
    tx_valid   = (count_q != '0);
    pop        = tx_valid & bus.tx_ready;
    push       = inflight_q;

    if (pop) begin
      send_cnt_d = send_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          rd_cnt_d   = '0;
          send_cnt_d = '0;
        end
      end
      S_FETCH: begin
        rd_en = credit_ok;
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && (send_cnt_q == LAST_IDX)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // SRAM data lands one cycle after rd_en; the in-flight flag marks that cycle as a push.
  always_comb begin
    inflight_d = rd_en;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fifo_mem_d = fifo_mem_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = bus.rd_data;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_cnt_q   <= '0;
      send_cnt_q <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      send_cnt_q <= send_cnt_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is visible.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign bus.rd_en    = rd_en;
  assign bus.rd_addr  = rd_cnt_q;
  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign bus.tx_last  = tx_valid & (send_cnt_q == LAST_IDX);
  assign busy         = (state_q != S_IDLE);

`ifdef READBACK_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == S_IDLE) && start) begin
      checksum_d = '0;
    end else if (pop) begin
      checksum_d = checksum_q + 16'(bus.tx_data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_pixel_readback_tx.sv
// tb/tb_pixel_readback_tx.sv - directed and randomized readback runs against a transaction-level model
module tb_pixel_readback_tx;
  localparam int IMAGEX = 64;
  localparam int IMAGEY = 64;
  localparam int N      = IMAGEX * IMAGEY;
  localparam int AW     = $clog2(N);
  localparam int DW     = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
`ifdef READBACK_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  pixel_readback_tx_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  pixel_readback_tx #(
    .IMAGEX(IMAGEX), .IMAGEY(IMAGEY), .RGB_SIZE(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bus(bus),
    .busy(busy),
    .done(done)
`ifdef READBACK_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [N];

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc, done_cyc;
  int issued, accepted, done_cnt;
  int data_err, last_err, credit_err, addr_err, stab_err, rden_err;
  bit active;
  bit pend_valid;
  logic [DW-1:0] pend_data;
  logic [15:0] cks_model;
  int rmode;
  logic start_nx, rst_nx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    issued = 0; accepted = 0; done_cnt = 0;
    data_err = 0; last_err = 0; credit_err = 0; addr_err = 0; stab_err = 0; rden_err = 0;
    active = 0; pend_valid = 0; cks_model = '0;
    start_cyc = 0; done_cyc = 0;
  endtask

  // One clock: drive inputs just after the edge, observe at the falling edge and update the model.
  task automatic tick();
    bit exp_rd;
    @(posedge clk);
    #2;
    start = start_nx;
    rst_n = rst_nx;
    case (rmode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = ($urandom_range(0, 99) < 30);
      default: bus.tx_ready = 1'b0;
    endcase
    @(negedge clk);
    cyc++;
    exp_rd = active && (issued < N) && ((issued - accepted) < DEPTH);
    if (bus.rd_en !== exp_rd) rden_err++;
    if (bus.rd_en === 1'b1) begin
      if ((issued - accepted) >= DEPTH) credit_err++;
      if (bus.rd_addr !== issued[AW-1:0]) addr_err++;
      issued++;
    end
    if (pend_valid && (bus.tx_valid !== 1'b1 || bus.tx_data !== pend_data)) stab_err++;
    if (bus.tx_valid === 1'b1) begin
      if (bus.tx_last !== (accepted == N - 1)) last_err++;
    end else if (bus.tx_last !== 1'b0) begin
      last_err++;
    end
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      if (accepted >= N || bus.tx_data !== mem[accepted]) data_err++;
      cks_model = cks_model + 16'(bus.tx_data);
      accepted++;
    end
    pend_valid = (bus.tx_valid === 1'b1) && (bus.tx_ready === 1'b0);
    pend_data  = bus.tx_data;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (start === 1'b1 && busy === 1'b0 && rst_n === 1'b1) begin
      active    = 1;
      start_cyc = cyc;
    end
    if (rst_n === 1'b0) begin
      active     = 0;
      pend_valid = 0;
    end
  endtask

  task automatic start_run();
    start_nx = 1'b1;
    tick();
    start_nx = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int budget;
    budget = (rmode == 1) ? 6 * N : N + 50;
    while (done_cnt == 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk({tag, "_timeout"}, 32'(done_cnt == 0), 32'd0);
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_beats"}, accepted, N);
    chk({tag, "_data"}, data_err, 0);
    chk({tag, "_last"}, last_err, 0);
    chk({tag, "_addr"}, addr_err, 0);
    chk({tag, "_rden"}, rden_err, 0);
    chk({tag, "_credit"}, credit_err, 0);
    chk({tag, "_stable"}, stab_err, 0);
    for (int i = 0; i < 4; i++) tick();
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
    chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_tx_last"}, 32'(bus.tx_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
`ifdef READBACK_CHECKSUM_EN
    chk({tag, "_checksum"}, 32'(checksum), 32'd0);
`endif
  endtask

  initial begin
    int b;
    int bad;
    bit sent;
    rst_n = 1'b0; start = 1'b0; bus.tx_ready = 1'b0;
    rst_nx = 1'b0; start_nx = 1'b0; rmode = 2;
    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    clear_model();
    for (int i = 0; i < 3; i++) tick();
    check_idle_outputs("reset");
    rst_nx = 1'b1;
    tick();

    // Full rate: latency start -> done is IMAGE_SIZE + 3.
    clear_model(); rmode = 0;
    start_run();
    wait_done("full");
    chk("full_latency", done_cyc - start_cyc, N + 3);
    check_run("full");

    // Random back-pressure, random image.
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    clear_model(); rmode = 1;
    start_run();
    wait_done("bp");
    check_run("bp");

    // Stall hold after first valid.
    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    clear_model(); rmode = 2;
    start_run();
    b = 0;
    while (bus.tx_valid !== 1'b1 && b < 10) begin tick(); b++; end
    chk("stall_first_valid", 32'(bus.tx_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h00) bad++;
    end
    chk("stall_hold", bad, 0);
    chk("stall_reads", issued, DEPTH);
    rmode = 0;
    wait_done("stall");
    check_run("stall");

    // Second start mid-run is ignored.
    clear_model(); rmode = 0; sent = 0;
    start_run();
    b = 2 * N;
    while (done_cnt == 0 && b > 0) begin
      if (accepted == 100 && !sent) begin start_nx = 1'b1; sent = 1; end
      tick();
      start_nx = 1'b0;
      b--;
    end
    chk("restart_sent", 32'(sent), 32'd1);
    check_run("restart");

    // Reset mid-stream, then a clean run from address 0.
    clear_model(); rmode = 0;
    start_run();
    b = 3 * N;
    while (accepted < 2000 && b > 0) begin tick(); b--; end
    chk("midrst_reached", accepted, 2000);
    rst_nx = 1'b0;
    tick();
    rst_nx = 1'b1;
    tick();
    check_idle_outputs("midrst");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.tx_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("midrst_quiet", bad, 0);
    clear_model();
    start_run();
    wait_done("after_rst");
    check_run("after_rst");

`ifdef READBACK_CHECKSUM_EN
    for (int i = 0; i < N; i++) mem[i] = 8'hFF;
    clear_model(); rmode = 0;
    start_run();
    wait_done("cks_ff");
    chk("cks_ff_model", 32'(cks_model), 32'h0000F000);
    chk("cks_ff", 32'(checksum), 32'(cks_model));
    check_run("cks_ff");
    chk("cks_ff_hold", 32'(checksum), 32'h0000F000);
    for (int i = 0; i < N; i++) mem[i] = 8'h01;
    clear_model();
    start_run();
    wait_done("cks_01");
    chk("cks_01", 32'(checksum), 32'h00001000);
    check_run("cks_01");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
